phase_sync_rx: RTL and testbench

PHASE_SYNC_RX -- requirements
Module: phase_sync_rx

---
 rtl/phase_sync_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_phase_sync_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sync_rx.sv
// -----------------------------------------------------------------------------
// phase_sync_rx
//
// Purpose:
//   Phase-sequence synchroniser for a receiver that sees a repeating
//   three-symbol phase pattern 0 -> 1 -> 2 -> 0 ...  The block searches for
//   the pattern, verifies it over LOCK_THRESH consecutive correct symbols,
//   declares lock, and then flywheels the expected phase while tolerating
//   up to UNLOCK_THRESH-1 consecutive bad symbols before dropping lock.
//   Bad symbols seen while locked are counted in a saturating error counter.
//
// Parameters:
//   LOCK_THRESH    consecutive correct symbols needed to lock (2..7)
//   UNLOCK_THRESH  consecutive bad symbols while locked to drop lock (2..7)
//   CNT_WIDTH      width of err_count
//
// Ports:
//   clock           in   single rising-edge clock
//   reset           in   synchronous active-high reset
//   in_valid        in   in_phase is sampled only when high
//   in_phase[1:0]   in   0=IDLE, 1=STATE_1, 2=STATE_2, 3=illegal
//   clear_count     in   synchronous clear of err_count
//   locked          out  high in LOCKED and HOLD
//   expected_phase  out  next phase code the block expects
//   phase_err       out  one-cycle pulse per bad symbol while locked
//   lock_acq        out  one-cycle pulse on VERIFY -> LOCKED
//   lock_lost       out  one-cycle pulse on HOLD -> SEARCH
//   err_count       out  saturating count of phase_err pulses
//   sync_state      out  SEARCH=0, VERIFY=1, LOCKED=2, HOLD=3
// -----------------------------------------------------------------------------
module phase_sync_rx #(
  parameter int LOCK_THRESH   = 3,
  parameter int UNLOCK_THRESH = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           in_phase,
  input  logic                 clear_count,
  output logic                 locked,
  output logic [1:0]           expected_phase,
  output logic                 phase_err,
  output logic                 lock_acq,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [1:0]           sync_state
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [2:0]           LOCK_T   = 3'(LOCK_THRESH);
  localparam logic [2:0]           UNLOCK_T = 3'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [1:0]           ILLEGAL  = 2'd3;

  // Next phase in the 0 -> 1 -> 2 -> 0 cycle. Code 3 never appears as an
  // argument in normal operation; it maps to 0 so the result stays legal.
  function automatic logic [1:0] succ(input logic [1:0] p);
    case (p)
      2'd0:    succ = 2'd1;
      2'd1:    succ = 2'd2;
      default: succ = 2'd0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             expected_q, expected_d;
  logic [2:0]             match_cnt_q, match_cnt_d;
  logic [2:0]             miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic                   phase_err_q, phase_err_d;
  logic                   lock_acq_q, lock_acq_d;
  logic                   lock_lost_q, lock_lost_d;

  logic                   sym_match;
  logic                   sym_legal;
  logic                   err_inc;

  // expected_q is always a legal code, so an illegal symbol can never match.
  assign sym_match = (in_phase == expected_q);
  assign sym_legal = (in_phase != ILLEGAL);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    phase_err_d = 1'b0;
    lock_acq_d  = 1'b0;
    lock_lost_d = 1'b0;
    err_inc     = 1'b0;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (sym_legal) begin
            expected_d  = succ(in_phase);
            match_cnt_d = 3'd1;
            state_d     = VERIFY;
          end
        end

        VERIFY: begin
          if (sym_match) begin
            match_cnt_d = match_cnt_q + 3'd1;
            expected_d  = succ(in_phase);
            if (match_cnt_q + 3'd1 == LOCK_T) begin
              state_d    = LOCKED;
              lock_acq_d = 1'b1;
            end
          end else if (sym_legal) begin
            // A legal but out-of-order symbol starts a fresh candidate
            // sequence rather than throwing the search away.
            expected_d  = succ(in_phase);
            match_cnt_d = 3'd1;
          end else begin
            match_cnt_d = 3'd0;
            state_d     = SEARCH;
          end
        end

        LOCKED: begin
          // The expected phase keeps advancing on bad symbols too, so a
          // single corrupted symbol does not shift the phase reference.
          expected_d = succ(expected_q);
          if (sym_match) begin
            miss_cnt_d = 3'd0;
          end else begin
            phase_err_d = 1'b1;
            err_inc     = 1'b1;
            miss_cnt_d  = 3'd1;
            state_d     = HOLD;
          end
        end

        HOLD: begin
          expected_d = succ(expected_q);
          if (sym_match) begin
            miss_cnt_d = 3'd0;
            state_d    = LOCKED;
          end else begin
            phase_err_d = 1'b1;
            err_inc     = 1'b1;
            miss_cnt_d  = miss_cnt_q + 3'd1;
            if (miss_cnt_q + 3'd1 == UNLOCK_T) begin
              state_d     = SEARCH;
              lock_lost_d = 1'b1;
              match_cnt_d = 3'd0;
            end
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    // Recovery from a corrupted state register does not wait for a valid
    // symbol.
    if (state_q != SEARCH && state_q != VERIFY &&
        state_q != LOCKED && state_q != HOLD) begin
      state_d = SEARCH;
    end

    // Clear wins over a simultaneous increment; the counter never wraps.
    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SEARCH;
      expected_q  <= 2'd0;
      match_cnt_q <= 3'd0;
      miss_cnt_q  <= 3'd0;
      err_count_q <= '0;
      phase_err_q <= 1'b0;
      lock_acq_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      phase_err_q <= phase_err_d;
      lock_acq_q  <= lock_acq_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // ---------------------------------------------------------------------------
  assign locked         = (state_q == LOCKED) || (state_q == HOLD);
  assign expected_phase = expected_q;
  assign phase_err      = phase_err_q;
  assign lock_acq       = lock_acq_q;
  assign lock_lost      = lock_lost_q;
  assign err_count      = err_count_q;
  assign sync_state     = state_q;

endmodule

// File: tb/tb_phase_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_phase_sync_rx
//
// Drives two phase_sync_rx instances (CNT_WIDTH=8 and CNT_WIDTH=2) with the
// same stimulus. Each driven cycle pushes the expected outputs from a small
// behavioural model into a queue; after the clock edge the entry is popped
// and compared against both DUTs. Directed spot checks with fixed constants
// back up the model at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_phase_sync_rx;

  localparam int LOCK   = 3;
  localparam int UNLOCK = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_phase;
  logic       clear_count;

  logic       locked, locked2;
  logic [1:0] expected_phase, expected_phase2;
  logic       phase_err, phase_err2;
  logic       lock_acq, lock_acq2;
  logic       lock_lost, lock_lost2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [1:0] sync_state, sync_state2;

  phase_sync_rx #(.LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_phase(in_phase),
    .clear_count(clear_count), .locked(locked), .expected_phase(expected_phase),
    .phase_err(phase_err), .lock_acq(lock_acq), .lock_lost(lock_lost),
    .err_count(err_count), .sync_state(sync_state)
  );

  phase_sync_rx #(.LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK), .CNT_WIDTH(2)) dut_w2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_phase(in_phase),
    .clear_count(clear_count), .locked(locked2), .expected_phase(expected_phase2),
    .phase_err(phase_err2), .lock_acq(lock_acq2), .lock_lost(lock_lost2),
    .err_count(err_count2), .sync_state(sync_state2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int locked;
    int exp_ph;
    int pe;
    int acq;
    int lost;
    int err;
    int err2;
    int st;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model state
  int m_state, m_exp, m_match, m_miss, m_err, m_err2;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cycle, act, exp);
    end
  endtask

  function automatic int nxt(input int p);
    int tbl[3];
    tbl[0] = 1; tbl[1] = 2; tbl[2] = 0;
    return (p >= 0 && p < 3) ? tbl[p] : 0;
  endfunction

  // Advance the model by one clock edge and return the outputs expected after it.
  function automatic exp_t model_step(input bit rst, input bit v, input int p, input bit clr);
    exp_t e;
    bit bad;
    e.pe = 0; e.acq = 0; e.lost = 0;
    bad = 0;
    if (rst) begin
      m_state = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0; m_err2 = 0;
    end else begin
      if (v) begin
        if (m_state == 0) begin
          if (p != 3) begin m_exp = nxt(p); m_match = 1; m_state = 1; end
        end else if (m_state == 1) begin
          if (p == m_exp) begin
            m_match = m_match + 1;
            m_exp = nxt(p);
            if (m_match == LOCK) begin m_state = 2; e.acq = 1; end
          end else if (p != 3) begin
            m_exp = nxt(p); m_match = 1;
          end else begin
            m_state = 0; m_match = 0;
          end
        end else begin
          bad = (p != m_exp);
          m_exp = nxt(m_exp);
          if (!bad) begin
            m_miss = 0; m_state = 2;
          end else if (m_state == 2) begin
            m_miss = 1; m_state = 3;
          end else begin
            m_miss = m_miss + 1;
            if (m_miss == UNLOCK) begin m_state = 0; e.lost = 1; m_match = 0; end
          end
        end
      end
      e.pe = bad;
      if (clr) begin
        m_err = 0; m_err2 = 0;
      end else if (bad) begin
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
      end
    end
    e.locked = (m_state >= 2) ? 1 : 0;
    e.exp_ph = m_exp;
    e.err    = m_err;
    e.err2   = m_err2;
    e.st     = m_state;
    return e;
  endfunction

  // One transaction: drive, push expectation, clock, pop and compare.
  task automatic drive(input bit rst, input bit v, input int p, input bit clr);
    exp_t e;
    reset       = rst;
    in_valid    = v;
    in_phase    = 2'(p);
    clear_count = clr;
    sb_q.push_back(model_step(rst, v, p, clr));
    @(posedge clock);
    #1;
    cycle++;
    e = sb_q.pop_front();
    $display("cyc %0d rst=%0d v=%0d ph=%0d clr=%0d -> st=%0d lk=%0d exp=%0d pe=%0d acq=%0d lost=%0d err=%0d err2=%0d",
             cycle, rst, v, p, clr, sync_state, locked, expected_phase, phase_err,
             lock_acq, lock_lost, err_count, err_count2);
    check("sync_state", int'(sync_state), e.st);
    check("locked", int'(locked), e.locked);
    check("expected_phase", int'(expected_phase), e.exp_ph);
    check("phase_err", int'(phase_err), e.pe);
    check("lock_acq", int'(lock_acq), e.acq);
    check("lock_lost", int'(lock_lost), e.lost);
    check("err_count", int'(err_count), e.err);
    check("w2_err_count", int'(err_count2), e.err2);
    check("w2_sync_state", int'(sync_state2), e.st);
    check("w2_phase_err", int'(phase_err2), e.pe);
  endtask

  task automatic send(input int p);
    drive(1'b0, 1'b1, p, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 0, 1'b0);
  endtask

  int sym;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_phase = 2'd0; clear_count = 1'b0;
    m_state = 0; m_exp = 0; m_match = 0; m_miss = 0; m_err = 0; m_err2 = 0;
    @(negedge clock);

    // Reset state, with in_valid and clear active to show reset dominates
    drive(1'b1, 1'b1, 1, 1'b1);
    check("rst_sync_state", int'(sync_state), 0);
    check("rst_err_count", int'(err_count), 0);

    // Acquire lock with 0,1,2
    send(0); send(1);
    check("pre_lock_acq", int'(lock_acq), 0);
    send(2);
    check("acq_pulse", int'(lock_acq), 1);
    check("acq_locked", int'(locked), 1);
    check("acq_expected", int'(expected_phase), 0);
    check("acq_state", int'(sync_state), 2);
    send(0);
    check("acq_pulse_once", int'(lock_acq), 0);

    // Single bad symbol while locked (expected is now 1): send 0, then 2,0,1
    send(0);
    check("err_pulse", int'(phase_err), 1);
    check("err_hold_state", int'(sync_state), 3);
    check("err_count_1", int'(err_count), 1);
    send(2); send(0); send(1);
    check("recover_state", int'(sync_state), 2);
    check("recover_locked", int'(locked), 1);
    check("recover_err_once", int'(err_count), 1);

    // Two consecutive bad symbols drop lock
    do_reset();
    send(0); send(1); send(2);
    send(3);
    check("unlock_first_err", int'(phase_err), 1);
    send(3);
    check("unlock_lost", int'(lock_lost), 1);
    check("unlock_locked", int'(locked), 0);
    check("unlock_state", int'(sync_state), 0);
    check("unlock_err", int'(err_count), 2);

    // Gap in in_valid during verification freezes everything
    do_reset();
    send(0);
    idle(); idle(); idle();
    check("gap_state", int'(sync_state), 1);
    check("gap_expected", int'(expected_phase), 1);
    send(1); send(2);
    check("gap_acq", int'(lock_acq), 1);

    // Illegal symbol during VERIFY returns to SEARCH without an error
    do_reset();
    send(0); send(1); send(3);
    check("verify_illegal_state", int'(sync_state), 0);
    check("verify_illegal_noerr", int'(phase_err), 0);
    // Legal mismatch in VERIFY re-seeds
    send(1); send(0);
    check("reseed_state", int'(sync_state), 1);
    check("reseed_expected", int'(expected_phase), 1);

    // Reset mid-LOCKED, coinciding with a bad symbol and a clear
    send(1); send(2);
    check("relock_state", int'(sync_state), 2);
    drive(1'b1, 1'b1, 3, 1'b1);
    check("midlock_rst_locked", int'(locked), 0);
    check("midlock_rst_pe", int'(phase_err), 0);
    check("midlock_rst_exp", int'(expected_phase), 0);

    // Saturation: alternate bad/good while locked to produce five errors
    do_reset();
    send(0); send(1); send(2);
    for (int i = 0; i < 5; i++) begin
      send(3);
      send(int'(expected_phase));
    end
    check("sat_w2", int'(err_count2), 3);
    check("sat_w8", int'(err_count), 5);
    // Error coinciding with clear
    drive(1'b0, 1'b1, 3, 1'b1);
    check("clr_pe", int'(phase_err), 1);
    check("clr_w2", int'(err_count2), 0);
    check("clr_w8", int'(err_count), 0);
    // Clear while idle also works
    send(int'(expected_phase)); send(3);
    drive(1'b0, 1'b0, 0, 1'b1);
    check("clr_idle", int'(err_count), 0);

    // Randomised run, mostly following the expected sequence
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 75) sym = m_exp;
      else sym = int'($urandom_range(0, 3));
      case ($urandom_range(0, 49))
        0:       drive(1'b1, 1'b1, sym, 1'b0);
        1:       drive(1'b0, 1'b1, sym, 1'b1);
        2, 3, 4: idle();
        default: send(sym);
      endcase
    end

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
